layer_mac_engine: RTL and testbench

- Datapath sequencer for one fully-connected hidden layer of the neural network.
- Sits directly downstream of the network controller: a load pulse (ld1 or ld2) starts it, and it returns the layer-done pulse the controller waits on.
- For each neuron, serially computes bias plus the sum over inputs of x[i]*w[n][i], requantizes and activates the result, then writes it to the layer output buffer.

---
 rtl/nn_pkg.sv | 36 +++
 rtl/mac_unit.sv | 56 +++++
 rtl/layer_mac_engine.sv | 171 +++++++++++++++++
 tb/tb_layer_mac_engine.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and arithmetic helpers for the layer MAC engine.
package nn_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BIAS  = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_e;

  localparam int DW_DEF    = 8;
  localparam int ACC_W_DEF = 24;
  localparam int SHIFT_DEF = 7;

  // Clamp to the signed range of a dw-bit value; 64-bit keeps it width-generic.
  function automatic logic signed [63:0] sat_dw(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) begin
      sat_dw = hi;
    end else if (v < lo) begin
      sat_dw = lo;
    end else begin
      sat_dw = v;
    end
  endfunction

  function automatic logic signed [63:0] relu(input logic signed [63:0] v);
    relu = (v < 64'sd0) ? 64'sd0 : v;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed DW x DW multiplier feeding an ACC_W accumulator with bias preload.
module mac_unit
  import nn_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_load_bias,
  input  logic             i_acc_en,
  input  logic [DW-1:0]    i_x,
  input  logic [DW-1:0]    i_w,
  input  logic [DW-1:0]    i_b,
  output logic [ACC_W-1:0] o_acc_nxt
);

  logic signed [2*DW-1:0]  w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_bias_ext;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic signed [ACC_W-1:0] r_acc;

  assign w_prod     = $signed(i_x) * $signed(i_w);
  assign w_prod_ext = {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};
  // Bias is pre-scaled so the final right shift leaves it at unit weight.
  assign w_bias_ext = $signed({{(ACC_W-DW){i_b[DW-1]}}, i_b}) <<< SHIFT;

  // Accumulator next value; exported so the writer sees the final sum on the DRAIN edge.
  always_comb begin
    w_acc_nxt = r_acc;
    if (i_clear) begin
      w_acc_nxt = '0;
    end else if (i_load_bias) begin
      w_acc_nxt = w_bias_ext;
    end else if (i_acc_en) begin
      w_acc_nxt = r_acc + w_prod_ext;
    end else begin
      w_acc_nxt = r_acc;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_acc_nxt;
    end
  end

  assign o_acc_nxt = w_acc_nxt;

endmodule

// File: rtl/layer_mac_engine.sv
// Serial neuron sequencer for one fully-connected layer.
// Build option: define LAYER_RELU_EN to clamp negative outputs to zero.
module layer_mac_engine
  import nn_pkg::*;
#(
  parameter int N_IN  = 62,
  parameter int N_OUT = 30,
  parameter int DW    = DW_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int SHIFT = SHIFT_DEF,
  localparam int XA_W = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int WA_W = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
  localparam int NA_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld,
  output logic [XA_W-1:0] x_addr,
  input  logic [DW-1:0]   x_data,
  output logic [WA_W-1:0] w_addr,
  input  logic [DW-1:0]   w_data,
  output logic [NA_W-1:0] b_addr,
  input  logic [DW-1:0]   b_data,
  output logic            out_we,
  output logic [NA_W-1:0] out_addr,
  output logic [DW-1:0]   out_data,
  output logic            busy,
  output logic            layer_done
);

  localparam logic [XA_W-1:0] I_LAST = XA_W'(N_IN - 1);
  localparam logic [NA_W-1:0] N_LAST = NA_W'(N_OUT - 1);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [NA_W-1:0] r_n;
  logic [NA_W-1:0] w_n_nxt;
  logic [XA_W-1:0] r_i;
  logic [XA_W-1:0] w_i_nxt;

  logic            w_clear;
  logic            w_load_bias;
  logic            w_acc_en;
  logic [ACC_W-1:0] w_acc_nxt;
  logic signed [ACC_W-1:0] w_acc_sh;
  logic signed [63:0]      w_acc_wide;

  logic [XA_W-1:0] w_x_addr_nxt;
  logic [WA_W-1:0] w_w_addr_nxt;
  logic [NA_W-1:0] w_b_addr_nxt;
  logic [DW-1:0]   w_out_nxt;

  mac_unit #(
    .DW    (DW),
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_mac (
    .clk         (clk),
    .rst_n       (rst),
    .i_clear     (w_clear),
    .i_load_bias (w_load_bias),
    .i_acc_en    (w_acc_en),
    .i_x         (x_data),
    .i_w         (w_data),
    .i_b         (b_data),
    .o_acc_nxt   (w_acc_nxt)
  );

  // Next-state and counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_n_nxt     = r_n;
    w_i_nxt     = r_i;
    case (r_state)
      IDLE: begin
        if (ld) begin
          w_state_nxt = BIAS;
          w_n_nxt     = '0;
          w_i_nxt     = '0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BIAS: begin
        w_state_nxt = MAC;
        w_i_nxt     = '0;
      end
      MAC: begin
        if (r_i == I_LAST) begin
          w_state_nxt = DRAIN;
        end else begin
          w_i_nxt = r_i + XA_W'(1);
        end
      end
      DRAIN: w_state_nxt = WRITE;
      WRITE: begin
        if (r_n == N_LAST) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = BIAS;
          w_n_nxt     = r_n + NA_W'(1);
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // MAC controls; data returned in the first MAC cycle belongs to the bias fetch.
  always_comb begin
    w_clear     = (r_state == IDLE);
    w_load_bias = (r_state == MAC) && (r_i == '0);
    w_acc_en    = ((r_state == MAC) && (r_i != '0)) || (r_state == DRAIN);
  end

  assign w_acc_sh   = $signed(w_acc_nxt) >>> SHIFT;
  assign w_acc_wide = {{(64-ACC_W){w_acc_sh[ACC_W-1]}}, w_acc_sh};

  // Registered outputs are decoded from the state being entered.
  always_comb begin
    w_x_addr_nxt = '0;
    w_w_addr_nxt = '0;
    w_b_addr_nxt = '0;
    if (w_state_nxt == MAC) begin
      w_x_addr_nxt = w_i_nxt;
      w_w_addr_nxt = WA_W'(w_n_nxt) * WA_W'(N_IN) + WA_W'(w_i_nxt);
    end else if (w_state_nxt == BIAS) begin
      w_w_addr_nxt = WA_W'(w_n_nxt) * WA_W'(N_IN);
      w_b_addr_nxt = w_n_nxt;
    end else begin
      w_w_addr_nxt = '0;
    end
`ifdef LAYER_RELU_EN
    w_out_nxt = DW'(relu(sat_dw(w_acc_wide, DW)));
`else
    w_out_nxt = DW'(sat_dw(w_acc_wide, DW));
`endif
  end

  // State, counters and all output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_n        <= '0;
      r_i        <= '0;
      x_addr     <= '0;
      w_addr     <= '0;
      b_addr     <= '0;
      out_we     <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
      busy       <= 1'b0;
      layer_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_n        <= w_n_nxt;
      r_i        <= w_i_nxt;
      x_addr     <= w_x_addr_nxt;
      w_addr     <= w_w_addr_nxt;
      b_addr     <= w_b_addr_nxt;
      out_we     <= (w_state_nxt == WRITE);
      out_addr   <= (w_state_nxt == WRITE) ? w_n_nxt : '0;
      busy       <= (w_state_nxt != IDLE);
      layer_done <= (r_state == DONE);
      if (w_state_nxt == WRITE) begin
        out_data <= w_out_nxt;
      end
    end
  end

endmodule

// File: tb/tb_layer_mac_engine.sv
// Directed bench for layer_mac_engine (N_IN=4, N_OUT=2, SHIFT=0).
module tb_layer_mac_engine;

  localparam int N_IN  = 4;
  localparam int N_OUT = 2;
  localparam int DW    = 8;
  localparam int ACC_W = 24;
  localparam int SHIFT = 0;
  localparam int LAT   = N_OUT * (N_IN + 3) + 1;

`ifdef LAYER_RELU_EN
  localparam int NEG_EXP  = 0;
  localparam int SATN_EXP = 0;
`else
  localparam int NEG_EXP  = -10;
  localparam int SATN_EXP = -128;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ld  = 1'b0;
  logic [1:0]    x_addr;
  logic [2:0]    w_addr;
  logic [0:0]    b_addr;
  logic [DW-1:0] x_data = '0;
  logic [DW-1:0] w_data = '0;
  logic [DW-1:0] b_data = '0;
  logic          out_we;
  logic [0:0]    out_addr;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          layer_done;

  logic signed [DW-1:0] x_mem [N_IN];
  logic signed [DW-1:0] w_mem [N_IN*N_OUT];
  logic signed [DW-1:0] b_mem [N_OUT];

  int n_checks = 0;
  int n_fail   = 0;
  int ncyc     = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int wr_addr[$];
  int wr_data[$];

  layer_mac_engine #(
    .N_IN (N_IN), .N_OUT (N_OUT), .DW (DW), .ACC_W (ACC_W), .SHIFT (SHIFT)
  ) dut (
    .clk (clk), .rst (rst), .ld (ld),
    .x_addr (x_addr), .x_data (x_data),
    .w_addr (w_addr), .w_data (w_data),
    .b_addr (b_addr), .b_data (b_data),
    .out_we (out_we), .out_addr (out_addr), .out_data (out_data),
    .busy (busy), .layer_done (layer_done)
  );

  always #5 clk = ~clk;

  // Synchronous ROMs: data valid one cycle after the address.
  always @(posedge clk) begin
    x_data <= x_mem[x_addr];
    w_data <= w_mem[w_addr];
    b_data <= b_mem[b_addr];
  end

  always @(negedge clk) begin
    ncyc++;
    if (out_we) begin
      wr_addr.push_back(int'(out_addr));
      wr_data.push_back(int'($signed(out_data)));
    end
    if (layer_done) begin
      done_cnt++;
      done_cyc = ncyc;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int q_at(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -999;
  endfunction

  task automatic set_basic();
    x_mem = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
    w_mem = '{8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd2, 8'sd0, 8'sd0, 8'sd1};
    b_mem = '{8'sd0, 8'sd5};
  endtask

  task automatic set_all(input logic signed [DW-1:0] xv, input logic signed [DW-1:0] wv);
    for (int k = 0; k < N_IN; k++) x_mem[k] = xv;
    for (int k = 0; k < N_IN * N_OUT; k++) w_mem[k] = wv;
    for (int k = 0; k < N_OUT; k++) b_mem[k] = 8'sd0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_ld(output int c);
    @(posedge clk);
    #1 ld = 1'b1;
    @(posedge clk);
    c = ncyc + 1;
    #1 ld = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target, output int prev_busy);
    int pb;
    pb = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (done_cnt >= target) break;
      pb = int'(busy);
    end
    prev_busy = pb;
    check(tag, int'(done_cnt >= target), 1);
  endtask

  task automatic run_check(input string tag, input int exp0, input int exp1);
    int c;
    int pb;
    clear_log();
    pulse_ld(c);
    wait_done({tag, "_done_seen"}, 1, pb);
    check({tag, "_latency"}, done_cyc - c, LAT);
    repeat (6) @(negedge clk);
    #1;
    check({tag, "_writes"}, wr_addr.size(), N_OUT);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_addr0"}, q_at(wr_addr, 0), 0);
    check({tag, "_data0"}, q_at(wr_data, 0), exp0);
    check({tag, "_addr1"}, q_at(wr_addr, 1), 1);
    check({tag, "_data1"}, q_at(wr_data, 1), exp1);
  endtask

  initial begin
    int c;
    int pb;
    set_basic();
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_we", int'(out_we), 0);
    check("rst_done", int'(layer_done), 0);
    check("rst_addrs", int'(x_addr) + int'(w_addr) + int'(b_addr) + int'(out_addr), 0);
    check("rst_data", int'(out_data), 0);
    rst = 1'b1;

    run_check("basic", 10, 11);

    w_mem[0] = -8'sd1; w_mem[1] = -8'sd1; w_mem[2] = -8'sd1; w_mem[3] = -8'sd1;
    run_check("neg", NEG_EXP, 11);

    set_all(8'sd127, 8'sd127);
    run_check("sat_pos", 127, 127);
    set_all(8'sd127, -8'sd128);
    run_check("sat_neg", SATN_EXP, SATN_EXP);

    // Extra ld pulses during MAC and DONE must be ignored.
    set_basic();
    clear_log();
    pulse_ld(c);
    repeat (3) @(posedge clk);
    #1 ld = 1'b1;
    @(posedge clk);
    #1 ld = 1'b0;
    repeat (10) @(posedge clk);
    #1 ld = 1'b1;
    @(posedge clk);
    #1 ld = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    check("extra_writes", wr_addr.size(), N_OUT);
    check("extra_done_pulses", done_cnt, 1);
    check("extra_idle", int'(busy), 0);
    check("extra_data1", q_at(wr_data, 1), 11);
    run_check("extra_fresh", 10, 11);

    // Reset during neuron 1 MAC.
    clear_log();
    pulse_ld(c);
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_we", int'(out_we), 0);
    check("midrst_addrs", int'(x_addr) + int'(w_addr) + int'(b_addr) + int'(out_addr), 0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    check("midrst_no_done", done_cnt, 0);
    check("midrst_writes", wr_addr.size(), 1);
    run_check("after_rst", 10, 11);

    // Back-to-back passes: ld raised during the layer_done cycle.
    clear_log();
    pulse_ld(c);
    wait_done("b2b_first_done", 1, pb);
    check("b2b_busy_in_done", pb, 1);
    check("b2b_busy_idle", int'(busy), 0);
    ld = 1'b1;
    @(posedge clk);
    c = ncyc + 1;
    #1 ld = 1'b0;
    check("b2b_busy_restart", int'(busy), 1);
    wait_done("b2b_second_done", 2, pb);
    check("b2b_latency", done_cyc - c, LAT);
    repeat (4) @(negedge clk);
    #1;
    check("b2b_writes", wr_addr.size(), 2 * N_OUT);
    check("b2b_addr2", q_at(wr_addr, 2), 0);
    check("b2b_data2", q_at(wr_data, 2), 10);
    check("b2b_addr3", q_at(wr_addr, 3), 1);
    check("b2b_data3", q_at(wr_data, 3), 11);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
